// File: rtl/pvt_ts_sequencer.sv
//------------------------------------------------------------------------------
// pvt_ts_sequencer
//
// Sequences the PVT temperature/voltage sensor macro: powers it up, waits for
// the analog front end to settle, then walks the enabled SEL codes issuing a
// start-of-conversion pulse per channel and capturing each 12-bit result on
// the end-of-conversion event. A channel whose EOC never arrives is skipped
// with a timeout pulse. Optionally wraps around for continuous scanning.
//
// Ports:
//   i_clk           sequencer clock (same clock as the sensor CLK_TS)
//   i_rst_n         asynchronous active-low reset
//   i_start         one-cycle scan request (ignored while busy or mask = 0)
//   i_abort         stop the scan on the next edge
//   i_continuous    wrap to the first channel after the last one
//   i_ch_mask       bit n enables SEL code n (0 = temperature, 1..14 = VOL_TS)
//   i_ts_eoc        sensor end-of-conversion, asynchronous to i_clk
//   i_ts_data       sensor 12-bit result
//   o_ts_en         sensor EN_TS / EN_ADC_TS
//   o_ts_soc        sensor SOC_TS
//   o_ts_sel        sensor SEL_TS
//   o_busy          scan in progress
//   o_sample_valid  one-cycle result strobe
//   o_sample_ch     SEL code of the strobed result
//   o_sample_data   captured result
//   o_timeout       one-cycle pulse when a channel is skipped
//------------------------------------------------------------------------------
module pvt_ts_sequencer #(
   parameter int SETTLE_CYCLES = 64,
   parameter int SOC_CYCLES    = 2,
   parameter int EOC_TIMEOUT   = 4096
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic        i_continuous,
   input  logic [14:0] i_ch_mask,
   input  logic        i_ts_eoc,
   input  logic [11:0] i_ts_data,
   output logic        o_ts_en,
   output logic        o_ts_soc,
   output logic [3:0]  o_ts_sel,
   output logic        o_busy,
   output logic        o_sample_valid,
   output logic [3:0]  o_sample_ch,
   output logic [11:0] o_sample_data,
   output logic        o_timeout
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SETTLE   = 3'd1;
   localparam logic [2:0] ST_SOC      = 3'd2;
   localparam logic [2:0] ST_WAIT_EOC = 3'd3;
   localparam logic [2:0] ST_NEXT     = 3'd4;

   // One shared counter serves settle, SOC width and EOC timeout.
   localparam int CNT_MAX_A = (SETTLE_CYCLES > SOC_CYCLES) ? SETTLE_CYCLES : SOC_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > EOC_TIMEOUT) ? CNT_MAX_A : EOC_TIMEOUT;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SOC_LAST     = CNT_W'(SOC_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(EOC_TIMEOUT - 1);

   // SEL code 15 does not exist in a 15-bit mask, so it marks "no higher bit".
   localparam logic [3:0] NO_BIT = 4'hF;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [14:0]      mask_r;
   logic             wrap_r;
   logic             eoc_meta;
   logic             eoc_sync;
   logic             eoc_prev;
   logic             eoc_event;
   logic [3:0]       lowest_sel;
   logic [3:0]       higher_sel;

   function automatic logic [3:0] lowest_bit(input logic [14:0] m);
      lowest_bit = 4'd0;
      for (int i = 14; i >= 0; i--)
         if (m[i]) lowest_bit = 4'(i);
   endfunction

   function automatic logic [3:0] next_bit(input logic [14:0] m, input logic [3:0] cur);
      next_bit = NO_BIT;
      for (int i = 14; i >= 0; i--)
         if (m[i] && (4'(i) > cur)) next_bit = 4'(i);
   endfunction

   assign lowest_sel = lowest_bit(mask_r);
   assign higher_sel = next_bit(mask_r, o_ts_sel);
   assign eoc_event  = eoc_sync & ~eoc_prev;
   assign o_busy     = (state != ST_IDLE);

   // EOC comes from the sensor's conversion logic and is treated as
   // asynchronous: two flops for metastability, a third for edge detect.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         eoc_meta <= 1'b0;
         eoc_sync <= 1'b0;
         eoc_prev <= 1'b0;
      end else begin
         eoc_meta <= i_ts_eoc;
         eoc_sync <= eoc_meta;
         eoc_prev <= eoc_sync;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         mask_r         <= '0;
         wrap_r         <= 1'b0;
         o_ts_en        <= 1'b0;
         o_ts_soc       <= 1'b0;
         o_ts_sel       <= '0;
         o_sample_valid <= 1'b0;
         o_sample_ch    <= '0;
         o_sample_data  <= '0;
         o_timeout      <= 1'b0;
      end else begin
         // Strobes default low so each is a single-cycle pulse.
         o_sample_valid <= 1'b0;
         o_timeout      <= 1'b0;

         if (state != ST_IDLE && i_abort) begin
            // Abort outranks an EOC event or timeout in the same cycle.
            state    <= ST_IDLE;
            cnt      <= '0;
            o_ts_en  <= 1'b0;
            o_ts_soc <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_start && (i_ch_mask != '0)) begin
                     mask_r   <= i_ch_mask;
                     o_ts_sel <= lowest_bit(i_ch_mask);
                     o_ts_en  <= 1'b1;
                     cnt      <= '0;
                     state    <= ST_SETTLE;
                  end
               end
               ST_SETTLE: begin
                  if (cnt == SETTLE_LAST) begin
                     cnt      <= '0;
                     o_ts_soc <= 1'b1;
                     state    <= ST_SOC;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_SOC: begin
                  if (cnt == SOC_LAST) begin
                     cnt      <= '0;
                     o_ts_soc <= 1'b0;
                     state    <= ST_WAIT_EOC;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_WAIT_EOC: begin
                  if (eoc_event || cnt == TIMEOUT_LAST) begin
                     if (eoc_event) begin
                        o_sample_data  <= i_ts_data;
                        o_sample_ch    <= o_ts_sel;
                        o_sample_valid <= 1'b1;
                     end else begin
                        o_timeout <= 1'b1;
                     end
                     // SEL advances on leaving WAIT_EOC so that it has been
                     // stable for the whole NEXT cycle before SOC rises.
                     cnt      <= '0;
                     wrap_r   <= (higher_sel == NO_BIT);
                     o_ts_sel <= (higher_sel == NO_BIT) ? lowest_sel : higher_sel;
                     state    <= ST_NEXT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_NEXT: begin
                  if (wrap_r && !i_continuous) begin
                     o_ts_en <= 1'b0;
                     state   <= ST_IDLE;
                  end else begin
                     cnt      <= '0;
                     o_ts_soc <= 1'b1;
                     state    <= ST_SOC;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pvt_ts_sequencer.sv
//------------------------------------------------------------------------------
// tb_pvt_ts_sequencer
//
// Directed bench for pvt_ts_sequencer with SETTLE_CYCLES=4, SOC_CYCLES=2,
// EOC_TIMEOUT=16. The bench plays the sensor: it raises EOC a fixed number of
// cycles after SOC falls and presents the result data. Outputs are sampled on
// the falling clock edge.
//------------------------------------------------------------------------------
module tb_pvt_ts_sequencer;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic        i_abort;
   logic        i_continuous;
   logic [14:0] i_ch_mask;
   logic        i_ts_eoc;
   logic [11:0] i_ts_data;
   logic        o_ts_en;
   logic        o_ts_soc;
   logic [3:0]  o_ts_sel;
   logic        o_busy;
   logic        o_sample_valid;
   logic [3:0]  o_sample_ch;
   logic [11:0] o_sample_data;
   logic        o_timeout;

   int n_cmp = 0;
   int n_err = 0;

   pvt_ts_sequencer #(
      .SETTLE_CYCLES (4),
      .SOC_CYCLES    (2),
      .EOC_TIMEOUT   (16)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (i_start),
      .i_abort        (i_abort),
      .i_continuous   (i_continuous),
      .i_ch_mask      (i_ch_mask),
      .i_ts_eoc       (i_ts_eoc),
      .i_ts_data      (i_ts_data),
      .o_ts_en        (o_ts_en),
      .o_ts_soc       (o_ts_soc),
      .o_ts_sel       (o_ts_sel),
      .o_busy         (o_busy),
      .o_sample_valid (o_sample_valid),
      .o_sample_ch    (o_sample_ch),
      .o_sample_data  (o_sample_data),
      .o_timeout      (o_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic start_scan(input logic [14:0] mask, input logic cont);
      @(negedge clk);
      i_ch_mask    = mask;
      i_continuous = cont;
      i_start      = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("en_on_start", o_ts_en, 1);
      check("busy_on_start", o_busy, 1);
   endtask

   // Waits for SOC to rise; SEL must already hold its value one cycle earlier.
   task automatic wait_soc_rise(output int cyc);
      logic [3:0] prev_sel;
      bit         seen;
      prev_sel = o_ts_sel;
      cyc      = 0;
      seen     = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         cyc++;
         if (o_ts_soc) begin
            seen = 1;
            check("sel_before_soc", o_ts_sel, prev_sel);
         end
         prev_sel = o_ts_sel;
      end
      check("soc_seen", seen, 1);
   endtask

   task automatic wait_soc_fall(output int width);
      bit fell;
      width = 1;
      fell  = 0;
      for (int i = 0; i < 20 && !fell; i++) begin
         @(negedge clk);
         if (!o_ts_soc) fell = 1;
         else width++;
      end
      check("soc_fell", fell, 1);
   endtask

   // One channel conversion as seen by the sensor. With give_eoc=0 the sensor
   // stays silent and the channel must be skipped by the timeout.
   task automatic convert(input logic [3:0] ch, input logic [11:0] data,
                          input bit give_eoc, output int wait_cyc);
      int w;
      bit seen;
      bit vld;
      wait_soc_rise(wait_cyc);
      check("sel_at_soc", o_ts_sel, ch);
      check("en_at_soc", o_ts_en, 1);
      wait_soc_fall(w);
      check("soc_width", w, 2);
      if (give_eoc) begin
         repeat (9) @(negedge clk);
         check("sel_hold_wait", o_ts_sel, ch);
         i_ts_data = data;
         i_ts_eoc  = 1'b1;
         seen = 0;
         for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (o_sample_valid) seen = 1;
         end
         check("valid_seen", seen, 1);
         if (seen) begin
            check("sample_ch", o_sample_ch, ch);
            check("sample_data", o_sample_data, data);
         end
         i_ts_eoc = 1'b0;
      end else begin
         seen = 0;
         vld  = 0;
         w    = 0;
         for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            w++;
            if (o_sample_valid) vld = 1;
            if (o_timeout) seen = 1;
         end
         check("timeout_seen", seen, 1);
         check("timeout_delay", w, 16);
         check("no_valid_on_timeout", vld, 0);
      end
   endtask

   task automatic expect_idle(input string tag);
      @(negedge clk);
      check({tag, "_en"}, o_ts_en, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_valid"}, o_sample_valid, 0);
   endtask

   // Watches a quiet period and flags any sensor or result activity.
   task automatic expect_quiet(input string tag, input int cycles);
      bit act;
      act = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (o_ts_en || o_ts_soc || o_sample_valid || o_timeout || o_busy) act = 1;
      end
      check(tag, act, 0);
   endtask

   initial begin
      int w;
      rst_n        = 1'b0;
      i_start      = 1'b0;
      i_abort      = 1'b0;
      i_continuous = 1'b0;
      i_ch_mask    = '0;
      i_ts_eoc     = 1'b0;
      i_ts_data    = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_en", o_ts_en, 0);
      check("rst_soc", o_ts_soc, 0);
      check("rst_sel", o_ts_sel, 0);
      check("rst_busy", o_busy, 0);
      check("rst_valid", o_sample_valid, 0);
      check("rst_ch", o_sample_ch, 0);
      check("rst_data", o_sample_data, 0);
      check("rst_timeout", o_timeout, 0);
      rst_n = 1'b1;

      // Single temperature channel, one-shot
      start_scan(15'h0001, 1'b0);
      convert(4'd0, 12'h5A3, 1, w);
      check("settle_len", w, 4);
      expect_idle("single");

      // Two channels, one settle period, in ascending order
      start_scan(15'h0006, 1'b0);
      convert(4'd1, 12'h0C1, 1, w);
      check("settle_len2", w, 4);
      convert(4'd2, 12'hABC, 1, w);
      check("no_resettle", w, 1);
      expect_idle("two_ch");

      // Channel 0 times out, channel 1 still converts
      start_scan(15'h0003, 1'b0);
      convert(4'd0, 12'h000, 0, w);
      convert(4'd1, 12'h123, 1, w);
      check("next_after_timeout", w, 1);
      expect_idle("timeout");

      // Continuous scan of channels 0 and 14, then abort racing an EOC event
      start_scan(15'h4001, 1'b1);
      convert(4'd0, 12'h111, 1, w);
      convert(4'd14, 12'hE0E, 1, w);
      check("cont_no_resettle", w, 1);
      convert(4'd0, 12'h222, 1, w);
      check("wrap_no_resettle", w, 1);
      convert(4'd14, 12'hFFF, 1, w);
      wait_soc_rise(w);
      check("wrap_sel", o_ts_sel, 0);
      wait_soc_fall(w);
      @(negedge clk);
      i_ts_data = 12'h333;
      i_ts_eoc  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_abort = 1'b1;           // EOC event is live during this cycle
      @(negedge clk);
      i_abort = 1'b0;
      check("abort_busy", o_busy, 0);
      check("abort_en", o_ts_en, 0);
      check("abort_soc", o_ts_soc, 0);
      check("abort_no_valid", o_sample_valid, 0);
      i_ts_eoc     = 1'b0;
      i_continuous = 1'b0;
      expect_quiet("abort_quiet", 20);

      // Start with an empty mask is ignored
      @(negedge clk);
      i_ch_mask = '0;
      i_start   = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("zero_mask_busy", o_busy, 0);
      check("zero_mask_en", o_ts_en, 0);
      expect_quiet("zero_mask_quiet", 8);

      // Restart during a scan and mask change mid-scan have no effect
      start_scan(15'h0002, 1'b0);
      @(negedge clk);
      i_ch_mask = 15'h0001;
      i_start   = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      convert(4'd1, 12'h7FF, 1, w);
      expect_idle("restart_ignored");
      expect_quiet("restart_quiet", 10);

      // Reset pulsed during WAIT_EOC clears outputs without waiting for a clock
      start_scan(15'h0001, 1'b0);
      wait_soc_rise(w);
      wait_soc_fall(w);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_en", o_ts_en, 0);
      check("midrst_soc", o_ts_soc, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_sel", o_ts_sel, 0);
      check("midrst_data", o_sample_data, 0);
      check("midrst_ch", o_sample_ch, 0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_quiet("post_rst_quiet", 25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pvt_ts_sequencer.md
PVT_TS_SEQUENCER -- requirements
Module: pvt_ts_sequencer

Drives the temperature/voltage sensor macro (enable, start-of-conversion, mux select), scans the selected channels and captures each 12-bit result.

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: i_clk, i_rst_n.
REQ-002 Parameter SETTLE_CYCLES, default 64: i_clk cycles between o_ts_en rising and the first SOC.
REQ-003 Parameter SOC_CYCLES, default 2: width of the o_ts_soc high pulse.
REQ-004 Parameter EOC_TIMEOUT, default 4096: maximum cycles to wait for EOC after the SOC pulse ends.
REQ-005 Ports (name, direction, width, meaning):
- i_clk  in  1  sequencer clock, same as the sensor CLK_TS
- i_rst_n  in  1  async active-low reset
- i_start  in  1  one-cycle request to begin a scan
- i_abort  in  1  stop the scan immediately
- i_continuous  in  1  wrap to the first channel after the last one
- i_ch_mask  in  15  bit n enables SEL code n (0 = temperature, 1..14 = VOL_TS[n-1])
- i_ts_eoc  in  1  sensor end-of-conversion (async)
- i_ts_data  in  12  sensor OUT_12BIT_TS
- o_ts_en  out  1  drives EN_TS and EN_ADC_TS
- o_ts_soc  out  1  drives SOC_TS
- o_ts_sel  out  4  drives SEL_TS
- o_busy  out  1  state is not IDLE
- o_sample_valid  out  1  one-cycle result strobe
- o_sample_ch  out  4  SEL code of the result
- o_sample_data  out  12  captured result
- o_timeout  out  1  one-cycle pulse when a channel is skipped

Function
REQ-006 i_ts_eoc SHALL pass through a 2-flop synchronizer; its synchronized rising edge is the "EOC event".
REQ-007 FSM states SHALL be IDLE, SETTLE, SOC, WAIT_EOC and NEXT.
REQ-008 IDLE: i_start=1 with a non-zero i_ch_mask SHALL register the mask, set o_ts_sel to the lowest set bit, assert o_ts_en and enter SETTLE on the next edge.
REQ-009 IDLE: i_start with i_ch_mask=0 SHALL be ignored; i_start while o_busy=1 SHALL be ignored.
REQ-010 SETTLE: the block SHALL count SETTLE_CYCLES cycles, then enter SOC.
REQ-011 SOC: o_ts_soc SHALL be high for exactly SOC_CYCLES cycles, then the block enters WAIT_EOC with the timeout counter cleared.
REQ-012 o_ts_sel SHALL be stable from one cycle before o_ts_soc rises until the EOC event.
REQ-013 WAIT_EOC, EOC event: i_ts_data SHALL be captured into o_sample_data in the same cycle; o_sample_ch = o_ts_sel and o_sample_valid = 1 for one cycle; then enter NEXT.
REQ-014 WAIT_EOC, counter reaches EOC_TIMEOUT with no event: the block SHALL pulse o_timeout for one cycle, produce no valid, and enter NEXT.
REQ-015 NEXT: o_ts_sel SHALL advance to the next higher set bit of the registered mask, then enter SOC.
REQ-016 NEXT, last set bit done, i_continuous=1: the block SHALL wrap to the lowest set bit and enter SOC without dropping o_ts_en or re-settling.
REQ-017 NEXT, last set bit done, i_continuous=0: the block SHALL enter IDLE and deassert o_ts_en.
REQ-018 i_abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with o_ts_en=0 and o_ts_soc=0 and no o_sample_valid; abort takes priority over an EOC event or timeout in the same cycle.
REQ-019 Changes to i_ch_mask or i_continuous during a scan SHALL have no effect until the next i_start; i_continuous is re-read only at wrap time.
REQ-020 A single-bit mask with i_continuous=1 SHALL repeatedly convert that one channel.

Reset
REQ-021 Reset SHALL force IDLE and clear every output to 0 (o_ts_sel=0, o_sample_data=0), plus all counters and synchronizer flops.
REQ-022 Reset asserted mid-scan SHALL drop o_ts_en and o_ts_soc asynchronously; there SHALL be no output activity after deassertion until a new i_start.

Verification
REQ-023 SETTLE_CYCLES=4, SOC_CYCLES=2, mask=0x0001, i_continuous=0, EOC after 10 cycles with data=0x5A3 -> one valid with ch=0, data=0x5A3; o_ts_en drops; o_busy=0.
REQ-024 mask=0x0006, i_continuous=0 -> valids for ch=1 then ch=2 in order; a single settle period; SEL held stable around each SOC.
REQ-025 EOC never asserted, EOC_TIMEOUT=16 -> o_timeout pulses 16 cycles after SOC falls, then the next channel starts; no valid.
REQ-026 mask=0x4001, i_continuous=1 -> sequence ch 0, 14, 0, 14 with o_ts_en held high; i_abort then gives IDLE on the next edge with no further valid.
REQ-027 i_start with mask=0 -> o_busy stays 0; i_start during a scan -> ignored; i_rst_n pulsed during WAIT_EOC -> all outputs 0 immediately.
